// File: rtl/io_regs_m_pkg.sv
// Shared definitions for the I/O register block: IO addresses, scan FSM states, button bit map.
package io_regs_m_pkg;

  localparam logic [15:0] ADDR_IN_VBLANK      = 16'h7000;
  localparam logic [15:0] ADDR_CLR_VBLANK_IRQ = 16'h7001;
  localparam logic [15:0] ADDR_CONTROLLER_1   = 16'h7002;
  localparam logic [15:0] ADDR_CONTROLLER_2   = 16'h7003;

  typedef enum logic [2:0] {
    SCAN_IDLE,
    SCAN_LATCH,
    SCAN_READ,
    SCAN_PULSE,
    SCAN_COMMIT
  } scan_state_e;

  // First serial bit from the pad lands in bit 7.
  localparam int unsigned BTN_A      = 7;
  localparam int unsigned BTN_B      = 6;
  localparam int unsigned BTN_SELECT = 5;
  localparam int unsigned BTN_START  = 4;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_RIGHT  = 0;

endpackage

// File: rtl/io_regs_m_controller_scan.sv
// Serial pad scanner: latches both pads, clocks out 8 bits each, commits results atomically.
module controller_scan_m
  import io_regs_m_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 8,
  parameter int unsigned LATCH_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       data_1,
  input  logic       data_2,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic [7:0] buttons_1,
  output logic [7:0] buttons_2
);

  localparam logic [7:0] LATCH_LAST = 8'(LATCH_CYCLES - 1);
  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  scan_state_e state;
  logic [7:0]  timer;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_1;
  logic [7:0]  shift_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCAN_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shift_1    <= '0;
      shift_2    <= '0;
      buttons_1  <= '0;
      buttons_2  <= '0;
      ctrl_latch <= 1'b0;
      ctrl_clk   <= 1'b0;
    end else begin
      case (state)
        SCAN_IDLE: begin
          if (start) begin
            state      <= SCAN_LATCH;
            ctrl_latch <= 1'b1;
            timer      <= '0;
          end
        end
        SCAN_LATCH: begin
          if (timer == LATCH_LAST) begin
            state      <= SCAN_READ;
            ctrl_latch <= 1'b0;
            timer      <= '0;
            bit_cnt    <= '0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        SCAN_READ: begin
          // Pad lines are active-low; sample at the end of the low phase.
          if (timer == PHASE_LAST) begin
            shift_1 <= {shift_1[6:0], ~data_1};
            shift_2 <= {shift_2[6:0], ~data_2};
            timer   <= '0;
            if (bit_cnt == 3'd7) begin
              state <= SCAN_COMMIT;
            end else begin
              state    <= SCAN_PULSE;
              ctrl_clk <= 1'b1;
            end
          end else begin
            timer <= timer + 8'd1;
          end
        end
        SCAN_PULSE: begin
          if (timer == PHASE_LAST) begin
            state    <= SCAN_READ;
            ctrl_clk <= 1'b0;
            bit_cnt  <= bit_cnt + 3'd1;
            timer    <= '0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        SCAN_COMMIT: begin
          buttons_1 <= shift_1;
          buttons_2 <= shift_2;
          state     <= SCAN_IDLE;
        end
        default: begin
          state      <= SCAN_IDLE;
          ctrl_latch <= 1'b0;
          ctrl_clk   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_regs_m.sv
// I/O register file at 0x7000..0x7003: vblank IRQ latch, read-data mux, and pad scanner.
module io_regs_m
  import io_regs_m_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 8,
  parameter int unsigned LATCH_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_read_en,
  input  logic       cpu_write_en,
  input  logic       SELECT_in_vblank,
  input  logic       SELECT_clr_vblank_irq,
  input  logic       SELECT_controller_1,
  input  logic       SELECT_controller_2,
  input  logic       vblank_start,
  input  logic       in_vblank,
  input  logic       ctrl_data_1,
  input  logic       ctrl_data_2,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic [7:0] cpu_data_out,
  output logic       cpu_data_out_en,
  output logic       vblank_irq_n
);

  logic       irq_flag;
  logic [7:0] buttons_1;
  logic [7:0] buttons_2;

  // Set has priority over the CPU acknowledge so a new vblank is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_flag <= 1'b0;
    end else if (vblank_start) begin
      irq_flag <= 1'b1;
    end else if (cpu_write_en && SELECT_clr_vblank_irq) begin
      irq_flag <= 1'b0;
    end
  end

  assign vblank_irq_n = ~irq_flag;

  always_comb begin
    cpu_data_out_en = cpu_read_en & (SELECT_in_vblank | SELECT_clr_vblank_irq |
                                     SELECT_controller_1 | SELECT_controller_2);
    cpu_data_out    = '0;
    if (cpu_read_en) begin
      if (SELECT_in_vblank)         cpu_data_out = {7'b0, in_vblank};
      else if (SELECT_controller_1) cpu_data_out = buttons_1;
      else if (SELECT_controller_2) cpu_data_out = buttons_2;
    end
  end

  controller_scan_m #(
    .CLK_DIV      (CLK_DIV),
    .LATCH_CYCLES (LATCH_CYCLES)
  ) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (vblank_start),
    .data_1     (ctrl_data_1),
    .data_2     (ctrl_data_2),
    .ctrl_latch (ctrl_latch),
    .ctrl_clk   (ctrl_clk),
    .buttons_1  (buttons_1),
    .buttons_2  (buttons_2)
  );

endmodule
